// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch requester and a data requester.
// Ports: clk/rst (sync, active-low); fetch side if_req/if_addr -> if_gnt/if_rvalid/if_rdata/if_err;
// data side d_req/d_we/d_funct3/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata/d_err;
// memory side mem_en/mem_we/mem_funct3/mem_addr/mem_wdata, mem_rdata valid one cycle after a read.
// Optional macro ARB_STARVE_GUARD_EN adds a fetch starvation guard bounded by STARVE_LIMIT.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  logic [1:0] owner_q, owner_d;
  logic       if_err_q, if_err_d, d_err_q, d_err_d;
  logic       starve_trip, if_al, d_al;
`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] cnt_q, cnt_d;
  assign starve_trip = cnt_q == LIMIT;
  // counts cycles fetch waited behind a data grant; saturates at the limit
  always_comb cnt_d = (!if_req || if_gnt) ? 4'd0 : (d_gnt && cnt_q != LIMIT) ? cnt_q + 4'd1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst) cnt_q <= 4'd0;
    else      cnt_q <= cnt_d;
`else
  // pure data-over-fetch priority; the limit has no effect in this build
  assign starve_trip = 1'b0 & (STARVE_LIMIT != 0);
`endif
  always_comb begin
    if_al      = if_addr[1:0] == 2'b00;
    d_al       = d_funct3[1:0] == 2'b10 ? d_addr[1:0] == 2'b00 :
                 d_funct3[1:0] == 2'b01 ? !d_addr[0] : 1'b1;
    d_gnt      = rst & d_req & ~(if_req & starve_trip);
    if_gnt     = rst & if_req & ~d_gnt;
    mem_en     = (if_gnt & if_al) | (d_gnt & d_al);
    mem_we     = d_gnt & d_we & d_al;
    mem_funct3 = !mem_en ? 3'b000 : d_gnt ? d_funct3 : 3'b010;
    mem_addr   = !mem_en ? 32'h0 : d_gnt ? d_addr : if_addr;
    mem_wdata  = (mem_en & d_gnt) ? d_wdata : 32'h0;
    // only reads expect a response; stores and misaligned grants leave no owner
    owner_d    = (if_gnt & if_al) ? OWN_IF : (d_gnt & d_al & ~d_we) ? OWN_D : OWN_NONE;
    if_err_d   = if_gnt & ~if_al;
    d_err_d    = d_gnt & ~d_al;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      owner_q  <= OWN_NONE;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      if_err_q <= if_err_d;
      d_err_q  <= d_err_d;
    end
  assign if_rvalid = owner_q == OWN_IF;
  assign d_rvalid  = owner_q == OWN_D;
  assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
  assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;
  assign if_err    = if_err_q;
  assign d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a reference model.
module tb_mem_port_arbiter;
  localparam int LIM = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [2:0] d_funct3;
  logic if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [2:0] mem_funct3;
  int checks = 0, failures = 0;
  int starve = 0;
  bit p_ird, p_ierr, p_drd, p_derr;
  logic [2:0] f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  always #5 clk = ~clk;
  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic bit aligned(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    return (a % sz) == 0;
  endfunction
  task automatic idle();
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
  endtask
  // called just after a falling edge with this cycle's inputs applied
  task automatic tick();
    bit trip, dg, ig, ia, da, men;
    #1;
    trip = GUARD && starve >= LIM;
    dg = rst && d_req && !(if_req && trip);
    ig = rst && if_req && !dg;
    ia = if_addr % 4 == 0;
    da = aligned(d_funct3, d_addr);
    men = (ig && ia) || (dg && da);
    chk("gnt", {if_gnt, d_gnt}, {ig, dg});
    chk("mem_ctl", {mem_en, mem_we, mem_funct3}, {men, dg && d_we && da, men ? (dg ? d_funct3 : 3'b010) : 3'b000});
    chk("mem_addr", mem_addr, men ? (dg ? d_addr : if_addr) : 32'h0);
    chk("mem_wdata", mem_wdata, (men && dg) ? d_wdata : 32'h0);
    chk("if_rsp", {if_rvalid, if_err, if_rdata}, {p_ird, p_ierr, p_ird ? mem_rdata : 32'h0});
    chk("d_rsp", {d_rvalid, d_err, d_rdata}, {p_drd, p_derr, p_drd ? mem_rdata : 32'h0});
    @(posedge clk);
    if (!rst) begin
      starve = 0; p_ird = 0; p_ierr = 0; p_drd = 0; p_derr = 0;
    end else begin
      p_ird = ig && ia; p_ierr = ig && !ia;
      p_drd = dg && da && !d_we; p_derr = dg && !da;
      if (!if_req || ig) starve = 0;
      else if (dg && starve < LIM) starve++;
    end
    @(negedge clk);
  endtask
  initial begin
    idle(); rst = 0; mem_rdata = 0;
    @(negedge clk);
    if_req = 1; d_req = 1; d_funct3 = 3'b010;
    #1 chk("rst_gnt", {if_gnt, d_gnt, mem_en, mem_we}, 4'b0000);
    tick();
    tick();
    chk("rst_rsp", {if_rvalid, if_err, d_rvalid, d_err}, 4'b0000);
    rst = 1; idle();
    tick();
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h12345678;
    #1 chk("r37_gnt", {if_gnt, d_gnt}, 2'b10);
    chk("r37_addr", mem_addr, 32'h40);
    chk("r37_f3", mem_funct3, 3'b010);
    tick();
    idle(); mem_rdata = 32'hCAFE0001;
    #1 chk("r37_rvalid", if_rvalid, 1);
    chk("r37_rdata", if_rdata, 32'hCAFE0001);
    tick();
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 1; d_funct3 = 3'b010; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    #1 chk("r38_gnt", {if_gnt, d_gnt}, 2'b01);
    chk("r38_we", {mem_en, mem_we}, 2'b11);
    chk("r38_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    idle();
    #1 chk("r38_norv", {if_rvalid, d_rvalid}, 2'b00);
    tick();
    d_req = 1; d_we = 0; d_funct3 = 3'b001; d_addr = 32'h103;
    #1 chk("r39_gnt", {d_gnt, mem_en}, 2'b10);
    tick();
    idle();
    #1 chk("r39_err", {d_err, d_rvalid}, 2'b10);
    tick();
    for (int i = 1; i <= 6; i++) begin
      if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 32'h200;
      #1 chk($sformatf("r40_c%0d", i), {if_gnt, d_gnt}, (GUARD && i == 5) ? 2'b10 : 2'b01);
      tick();
    end
    idle();
    tick();
    if_req = 1; if_addr = 32'h44;
    tick();
    idle(); rst = 0;
    tick();
    rst = 1; if_req = 1; if_addr = 32'h40;
    #1 chk("r41_norv", {if_rvalid, if_err}, 2'b00);
    chk("r41_gnt", {if_gnt, mem_addr}, {1'b1, 32'h40});
    tick();
    idle(); mem_rdata = 32'h0BADF00D;
    #1 chk("r41_rdata", {if_rvalid, if_rdata}, {1'b1, 32'h0BADF00D});
    tick();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(0, 24) != 0;
      if_req = $urandom_range(0, 9) < 7;
      d_req = $urandom_range(0, 9) < 7;
      d_we = $urandom_range(0, 1) == 1;
      d_funct3 = f3s[$urandom_range(0, 4)];
      if_addr = $urandom;
      d_addr = $urandom;
      if ($urandom_range(0, 1) == 1) if_addr[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) d_addr[1:0] = 2'b00;
      d_wdata = $urandom;
      mem_rdata = $urandom;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
